// File: rtl/clock_counter.sv
// 12-hour BCD wall clock (hh:mm:ss + AM/PM) with field write port; CLOCK_COUNTER_DAY_TICK_EN adds o_day.
// 1-cycle registered latency on every qualified i_ena edge; no backpressure, i_ena=0 freezes all state.
module clock_counter (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_ena,
  input  logic [1:0] i_sel,
  input  logic       i_wr,
  input  logic [7:0] i_in,
  output logic       o_pm,
  output logic [7:0] o_hh,
  output logic [7:0] o_mm,
  output logic [7:0] o_ss
`ifdef CLOCK_COUNTER_DAY_TICK_EN
  ,
  output logic       o_day
`endif
);

  logic [7:0] ss_d, ss_q;
  logic [7:0] mm_d, mm_q;
  logic [7:0] hh_d, hh_q;
  logic       pm_d, pm_q;
  logic       ss_carry, mm_carry;
`ifdef CLOCK_COUNTER_DAY_TICK_EN
  logic       day_d, day_q;
`endif

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    return (v[3:0] == 4'd9) ? {v[7:4] + 4'd1, 4'd0} : {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic valid_60(input logic [7:0] v);
    return (v[7:4] <= 4'd5) && (v[3:0] <= 4'd9);
  endfunction

  function automatic logic valid_hh(input logic [7:0] v);
    return ((v[7:4] == 4'd0) && (v[3:0] != 4'd0) && (v[3:0] <= 4'd9)) ||
           ((v[7:4] == 4'd1) && (v[3:0] <= 4'd2));
  endfunction

  assign ss_carry = (ss_q == 8'h59);
  assign mm_carry = ss_carry && (mm_q == 8'h59);

  always_comb begin
    ss_d = ss_q;
    mm_d = mm_q;
    hh_d = hh_q;
    pm_d = pm_q;
`ifdef CLOCK_COUNTER_DAY_TICK_EN
    day_d = 1'b0;
`endif
    if (i_ena) begin
      if (i_wr) begin
        case (i_sel)
          2'b00: if (valid_60(i_in)) ss_d = i_in;
          2'b01: if (valid_60(i_in)) mm_d = i_in;
          2'b10: if (valid_hh(i_in)) hh_d = i_in;
          2'b11: pm_d = i_in[0];
        endcase
      end else begin
        ss_d = ss_carry ? 8'h00 : bcd_inc(ss_q);
        if (ss_carry) mm_d = (mm_q == 8'h59) ? 8'h00 : bcd_inc(mm_q);
        if (mm_carry) begin
          hh_d = (hh_q == 8'h12) ? 8'h01 : bcd_inc(hh_q);
          // AM/PM flips only when the hour rolls 11 -> 12
          if (hh_q == 8'h11) begin
            pm_d = ~pm_q;
`ifdef CLOCK_COUNTER_DAY_TICK_EN
            day_d = pm_q;
`endif
          end
        end
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      ss_q <= 8'h00;
      mm_q <= 8'h00;
      hh_q <= 8'h12;
      pm_q <= 1'b0;
`ifdef CLOCK_COUNTER_DAY_TICK_EN
      day_q <= 1'b0;
`endif
    end else begin
      ss_q <= ss_d;
      mm_q <= mm_d;
      hh_q <= hh_d;
      pm_q <= pm_d;
`ifdef CLOCK_COUNTER_DAY_TICK_EN
      day_q <= day_d;
`endif
    end
  end

  assign o_ss = ss_q;
  assign o_mm = mm_q;
  assign o_hh = hh_q;
  assign o_pm = pm_q;
`ifdef CLOCK_COUNTER_DAY_TICK_EN
  assign o_day = day_q;
`endif

endmodule

// File: tb/tb_clock_counter.sv
// Bench for clock_counter: directed boundary cases plus random traffic against a seconds-of-day model.
module tb_clock_counter;

  logic       i_clk = 1'b0;
  logic       i_reset = 1'b1;
  logic       i_ena = 1'b0;
  logic [1:0] i_sel = 2'b00;
  logic       i_wr = 1'b0;
  logic [7:0] i_in = 8'h00;
  logic       o_pm;
  logic [7:0] o_hh, o_mm, o_ss;
`ifdef CLOCK_COUNTER_DAY_TICK_EN
  logic       o_day;
  int         day_cnt = 0;
`endif

  int checks = 0;
  int errors = 0;
  int t = 0;          // model time: seconds since 12:00:00 AM
  logic day_exp = 1'b0;

  always #5 i_clk = ~i_clk;

  clock_counter dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_ena(i_ena), .i_sel(i_sel), .i_wr(i_wr), .i_in(i_in),
    .o_pm(o_pm), .o_hh(o_hh), .o_mm(o_mm), .o_ss(o_ss)
`ifdef CLOCK_COUNTER_DAY_TICK_EN
    , .o_day(o_day)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic logic [31:0] exp_time();
    int h24 = t / 3600;
    int h12 = h24 % 12;
    if (h12 == 0) h12 = 12;
    return {7'd0, (h24 >= 12), to_bcd(h12), to_bcd((t / 60) % 60), to_bcd(t % 60)};
  endfunction

  function automatic logic [31:0] obs_time();
    return {7'd0, o_pm, o_hh, o_mm, o_ss};
  endfunction

  function automatic void model_edge(input logic ena, input logic wr, input logic [1:0] sel,
                                     input logic [7:0] din);
    int hi = int'(din[7:4]);
    int lo = int'(din[3:0]);
    int val = hi * 10 + lo;
    int pm_off = (t / 3600 >= 12) ? 12 : 0;
    day_exp = 1'b0;
    if (!ena) return;
    if (wr) begin
      case (sel)
        2'd0: if (hi <= 5 && lo <= 9) t = t - t % 60 + val;
        2'd1: if (hi <= 5 && lo <= 9) t = t - ((t / 60) % 60) * 60 + val * 60;
        2'd2: if (lo <= 9 && val >= 1 && val <= 12) t = ((val % 12) + pm_off) * 3600 + t % 3600;
        default: t = (((t / 3600) % 12) + (din[0] ? 12 : 0)) * 3600 + t % 3600;
      endcase
    end else begin
      t++;
      if (t == 86400) begin
        t = 0;
        day_exp = 1'b1;
      end
    end
  endfunction

  task automatic step(input logic ena, input logic wr, input logic [1:0] sel,
                      input logic [7:0] din, input bit do_chk);
    i_ena = ena; i_wr = wr; i_sel = sel; i_in = din;
    @(posedge i_clk);
    model_edge(ena, wr, sel, din);
    #2;
    if (do_chk) check("time", obs_time(), exp_time());
`ifdef CLOCK_COUNTER_DAY_TICK_EN
    if (o_day) day_cnt++;
    check("day", {31'd0, o_day}, {31'd0, day_exp});
`endif
  endtask

  task automatic run_ticks(input int n);
    repeat (n) step(1'b1, 1'b0, 2'd0, 8'h00, 1'b0);
  endtask

  task automatic wr_field(input logic [1:0] sel, input logic [7:0] din);
    step(1'b1, 1'b1, sel, din, 1'b1);
  endtask

  task automatic set_time(input logic pm, input logic [7:0] hh, input logic [7:0] mm,
                          input logic [7:0] ss);
    wr_field(2'd3, {7'd0, pm});
    wr_field(2'd2, hh);
    wr_field(2'd1, mm);
    wr_field(2'd0, ss);
  endtask

  initial begin
    logic [7:0] din;
    repeat (3) @(negedge i_clk);
    check("reset_state", obs_time(), {7'd0, 1'b0, 8'h12, 8'h00, 8'h00});
    @(negedge i_clk);
    i_reset = 1'b0;
    t = 0;
    // ena low must freeze everything, even with write traffic present
    repeat (8) step(1'b0, 1'($urandom), 2'($urandom), 8'($urandom), 1'b1);
    check("hold_after_reset", obs_time(), {7'd0, 1'b0, 8'h12, 8'h00, 8'h00});

    run_ticks(59);
    check("tick59", obs_time(), {7'd0, 1'b0, 8'h12, 8'h00, 8'h59});
    run_ticks(1);
    check("tick60", obs_time(), {7'd0, 1'b0, 8'h12, 8'h01, 8'h00});
    run_ticks(3540);
    check("tick3600", obs_time(), {7'd0, 1'b0, 8'h01, 8'h00, 8'h00});
    check("tick3600_model", obs_time(), exp_time());

    set_time(1'b0, 8'h11, 8'h59, 8'h50);
    repeat (20) step(1'b1, 1'b0, 2'd0, 8'h00, 1'b1);
    check("noon", obs_time(), {7'd0, 1'b1, 8'h12, 8'h00, 8'h10});

    set_time(1'b1, 8'h11, 8'h59, 8'h50);
`ifdef CLOCK_COUNTER_DAY_TICK_EN
    day_cnt = 0;
`endif
    repeat (20) step(1'b1, 1'b0, 2'd0, 8'h00, 1'b1);
    check("midnight", obs_time(), {7'd0, 1'b0, 8'h12, 8'h00, 8'h10});
`ifdef CLOCK_COUNTER_DAY_TICK_EN
    check("day_pulses", day_cnt, 1);
`endif

    set_time(1'b1, 8'h11, 8'h58, 8'h00);
    for (int i = 0; i < 3000; i++) begin
      din = ($urandom_range(1) == 1) ? 8'($urandom) : to_bcd($urandom_range(60));
      step(($urandom_range(3) != 0), ($urandom_range(7) == 0), 2'($urandom), din, 1'b1);
    end

    wr_field(2'd0, 8'h37);
    wr_field(2'd1, 8'h14);
    wr_field(2'd2, 8'h11);
    wr_field(2'd3, 8'h01);
    check("wr_seq", obs_time(), {7'd0, 1'b1, 8'h11, 8'h14, 8'h37});
    repeat (5) wr_field(2'd3, 8'h01);
    check("wr_frozen", obs_time(), {7'd0, 1'b1, 8'h11, 8'h14, 8'h37});
    step(1'b1, 1'b0, 2'd0, 8'h00, 1'b1);
    check("resume", obs_time(), {7'd0, 1'b1, 8'h11, 8'h14, 8'h38});

    wr_field(2'd0, 8'h37);
    wr_field(2'd2, 8'h13);
    wr_field(2'd2, 8'h00);
    wr_field(2'd2, 8'h1A);
    wr_field(2'd0, 8'h6A);
    wr_field(2'd0, 8'h60);
    wr_field(2'd1, 8'h5F);
    check("invalid_ignored", obs_time(), {7'd0, 1'b1, 8'h11, 8'h14, 8'h37});
    wr_field(2'd3, 8'hFE);
    check("pm_bit0", obs_time(), {7'd0, 1'b0, 8'h11, 8'h14, 8'h37});

    set_time(1'b1, 8'h05, 8'h39, 8'h59);
    step(1'b1, 1'b0, 2'd0, 8'h00, 1'b1);
    check("0540pm", obs_time(), {7'd0, 1'b1, 8'h05, 8'h40, 8'h00});
    #2;
    i_reset = 1'b1;
    #1;
    check("async_reset", obs_time(), {7'd0, 1'b0, 8'h12, 8'h00, 8'h00});
`ifdef CLOCK_COUNTER_DAY_TICK_EN
    check("async_reset_day", {31'd0, o_day}, 32'd0);
`endif
    #2;
    i_reset = 1'b0;
    t = 0;
    step(1'b1, 1'b0, 2'd0, 8'h00, 1'b1);
    check("post_reset_tick", obs_time(), {7'd0, 1'b0, 8'h12, 8'h00, 8'h01});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
